// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller: load-use bubble insertion, mul/div EX occupancy and taken-branch flush for the EX stage.
module hazard_stall_controller #(
    parameter int AW         = 8,
    parameter int MULDIV_LAT = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [AW-1:0]    rs1_ifid,
    input  logic [AW-1:0]    rs2_ifid,
    input  logic             uses_rs2_ifid,
    input  logic             memread_idex,
    input  logic             regwrite_idex,
    input  logic [AW-1:0]    rd_idex,
    input  logic             muldiv_idex,
    input  logic             branch_taken_ex,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             idex_hold,
    output logic             exmem_bubble,
    output logic             muldiv_start,
    output logic             muldiv_done,
    output logic [CNT_W-1:0] stall_count
);
    typedef enum logic [1:0] {RUN, LU_STALL, MD_BUSY} state_t;

    localparam logic [5:0] LAT_M1 = 6'(MULDIV_LAT - 1);

    state_t     state, state_n;
    logic [5:0] cnt, cnt_n;
    logic       lu;

    assign lu = memread_idex & regwrite_idex & (rd_idex != '0) &
                ((rd_idex == rs1_ifid) | (uses_rs2_ifid & (rd_idex == rs2_ifid)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= RUN;
            cnt         <= '0;
            stall_count <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (!pc_write && stall_count != '1)
                stall_count <= stall_count + CNT_W'(1);
        end
    end

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        idex_hold    = 1'b0;
        exmem_bubble = 1'b0;
        muldiv_start = 1'b0;
        muldiv_done  = 1'b0;
        case (state)
            RUN: begin
                if (branch_taken_ex) begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                end else if (muldiv_idex) begin
                    muldiv_start = 1'b1;
                    pc_write     = 1'b0;
                    ifid_write   = 1'b0;
                    idex_hold    = 1'b1;
                    exmem_bubble = 1'b1;
                    cnt_n        = LAT_M1;
                    state_n      = MD_BUSY;
                end else if (lu) begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                    state_n     = LU_STALL;
                end
            end
            LU_STALL: state_n = RUN;
            MD_BUSY: begin
                if (cnt != '0) begin
                    pc_write     = 1'b0;
                    ifid_write   = 1'b0;
                    idex_hold    = 1'b1;
                    exmem_bubble = 1'b1;
                    cnt_n        = cnt - 6'd1;
                end else begin
                    muldiv_done = 1'b1;
                    state_n     = RUN;
                end
            end
            default: state_n = RUN;
        endcase
        // Outputs are forced low for the whole time reset is asserted.
        if (!reset) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            ifid_flush   = 1'b0;
            idex_bubble  = 1'b0;
            idex_hold    = 1'b0;
            exmem_bubble = 1'b0;
            muldiv_start = 1'b0;
            muldiv_done  = 1'b0;
        end
    end
endmodule
